// File: rtl/mem_arbiter_n_pkg.sv
// Shared definitions for the N-channel main-memory arbiter.
// Optional feature macro: MEMARB_RR_EN (round-robin arbitration instead of
// fixed priority). Consumers import mem_arbiter_n_pkg::*.
package mem_arbiter_n_pkg;

  // Direction encoding on ch_rw / mem_rw
  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Arbiter FSM states
  typedef enum logic {
    MEMARB_IDLE  = 1'b0,
    MEMARB_GRANT = 1'b1
  } arb_state_e;

  // Increment a channel index, wrapping n-1 -> 0
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_pick.sv
// Rotating priority encoder: the first set request bit found when searching
// upward from 'start' (wrapping modulo NCH) wins. With start tied to 0 it
// degenerates to a lowest-index-wins fixed-priority encoder.
module mem_arb_pick #(
  parameter int NCH = 3,
  parameter int GW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [GW-1:0]  start,
  output logic           any,
  output logic [GW-1:0]  idx
);

  // Walk candidates from farthest to nearest so the nearest requester
  // (smallest distance from start) is the last and therefore winning write.
  always_comb begin
    int pos;
    pos = 0;
    any = |req;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % NCH;
      if (req[pos]) idx = GW'(pos);
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel arbiter granting exclusive burst access to the single
// main-memory port. A grant is held for a whole burst and released by
// mem_last; every burst is followed by one IDLE turnaround cycle in which
// the next winner is chosen.
// Optional feature macro: MEMARB_RR_EN -- round-robin arbitration with a
// rotating search pointer; when undefined, fixed priority (ch0 highest)
// and no pointer register exists.
module mem_arbiter_n
  import mem_arbiter_n_pkg::*;
#(
  parameter int  NCH        = 3,
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 16,
  localparam int GW         = $clog2(NCH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // requester side
  input  logic [NCH-1:0]            ch_enable,
  input  logic [NCH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NCH-1:0]            ch_rw,
  input  logic [NCH-1:0]            ch_op_size,
  input  logic [NCH-1:0]            ch_finishes_op,
  input  logic [NCH*DATA_WIDTH-1:0] ch_write,
  output logic [DATA_WIDTH-1:0]     ch_read,
  output logic [NCH-1:0]            ch_read_valid,
  output logic [NCH-1:0]            ch_req_data,
  output logic [NCH-1:0]            ch_last,
  // status
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  // RAM controller side
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      mem_enable,
  output logic                      mem_rw,
  output logic                      mem_op_size,
  output logic                      mem_finishes_op,
  output logic [DATA_WIDTH-1:0]     mem_write,
  input  logic                      mem_write_req_input,
  input  logic [DATA_WIDTH-1:0]     mem_read,
  input  logic                      mem_read_valid,
  input  logic                      mem_last
);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] pick_start;
  logic          pick_any;
  logic [GW-1:0] pick_idx;

`ifdef MEMARB_RR_EN
  // Search starts just past the previous winner, so every requester is
  // served within NCH-1 foreign bursts.
  logic [GW-1:0] rr_q, rr_d;
  assign pick_start = rr_q;
`else
  assign pick_start = '0;
`endif

  mem_arb_pick #(
    .NCH (NCH),
    .GW  (GW)
  ) u_pick (
    .req   (ch_enable),
    .start (pick_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  // State, grant index and (optional) round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEMARB_IDLE;
      grant_q <= '0;
`ifdef MEMARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef MEMARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Next-state: arbitrate only in IDLE; a grant is released solely by
  // mem_last, so requests that arrive mid-burst (or coincide with mem_last)
  // are considered in the following IDLE cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef MEMARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      MEMARB_IDLE: begin
        if (pick_any) begin
          state_d = MEMARB_GRANT;
          grant_d = pick_idx;
`ifdef MEMARB_RR_EN
          rr_d    = GW'(wrap_inc(int'(pick_idx), NCH));
`endif
        end
      end
      MEMARB_GRANT: begin
        if (mem_last) state_d = MEMARB_IDLE;
      end
      default: state_d = MEMARB_IDLE;
    endcase
  end

  assign busy     = (state_q == MEMARB_GRANT);
  assign grant_id = grant_q;

  // Datapath steering: RAM side muxed from the grantee, RAM responses routed
  // back to the grantee only. Everything is forced to 0 outside a grant so the
  // RAM never sees stale requests and idle channels never see strobes.
  always_comb begin
    mem_enable      = 1'b0;
    mem_addr        = '0;
    mem_rw          = MEM_READ;
    mem_op_size     = 1'b0;
    mem_finishes_op = 1'b0;
    mem_write       = '0;
    ch_read         = '0;
    ch_read_valid   = '0;
    ch_req_data     = '0;
    ch_last         = '0;
    if (busy) begin
      mem_enable = 1'b1;
      ch_read    = mem_read;
      for (int i = 0; i < NCH; i++) begin
        if (grant_q == GW'(i)) begin
          mem_addr         = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          mem_rw           = ch_rw[i];
          mem_op_size      = ch_op_size[i];
          mem_finishes_op  = ch_finishes_op[i];
          mem_write        = ch_write[i*DATA_WIDTH +: DATA_WIDTH];
          ch_read_valid[i] = mem_read_valid;
          ch_req_data[i]   = mem_write_req_input;
          ch_last[i]       = mem_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n (NCH=3). Inputs change on the falling
// edge; outputs are checked 1ns later. Builds with or without MEMARB_RR_EN.
module tb_mem_arbiter_n;
  import mem_arbiter_n_pkg::*;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int GW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_enable;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_rw;
  logic [NCH-1:0]    ch_op_size;
  logic [NCH-1:0]    ch_finishes_op;
  logic [NCH*DW-1:0] ch_write;
  logic [DW-1:0]     ch_read;
  logic [NCH-1:0]    ch_read_valid;
  logic [NCH-1:0]    ch_req_data;
  logic [NCH-1:0]    ch_last;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic [AW-1:0]     mem_addr;
  logic              mem_enable;
  logic              mem_rw;
  logic              mem_op_size;
  logic              mem_finishes_op;
  logic [DW-1:0]     mem_write;
  logic              mem_write_req_input;
  logic [DW-1:0]     mem_read;
  logic              mem_read_valid;
  logic              mem_last;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter_n #(.NCH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ch_enable           (ch_enable),
    .ch_addr             (ch_addr),
    .ch_rw               (ch_rw),
    .ch_op_size          (ch_op_size),
    .ch_finishes_op      (ch_finishes_op),
    .ch_write            (ch_write),
    .ch_read             (ch_read),
    .ch_read_valid       (ch_read_valid),
    .ch_req_data         (ch_req_data),
    .ch_last             (ch_last),
    .busy                (busy),
    .grant_id            (grant_id),
    .mem_addr            (mem_addr),
    .mem_enable          (mem_enable),
    .mem_rw              (mem_rw),
    .mem_op_size         (mem_op_size),
    .mem_finishes_op     (mem_finishes_op),
    .mem_write           (mem_write),
    .mem_write_req_input (mem_write_req_input),
    .mem_read            (mem_read),
    .mem_read_valid      (mem_read_valid),
    .mem_last            (mem_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq [3];
`ifdef MEMARB_RR_EN
    exp_seq = '{0, 1, 2};
`else
    exp_seq = '{0, 0, 0};
`endif

    // ---- 1. reset with every channel requesting
    rst_n               = 1'b0;
    ch_enable           = 3'b111;
    ch_addr             = {16'h0080, 16'h0040, 16'h0010};
    ch_rw               = {MEM_WRITE, MEM_READ, MEM_READ};
    ch_op_size          = 3'b100;
    ch_finishes_op      = 3'b100;
    ch_write            = {32'hCAFE_0002, 32'h1111_1111, 32'hA0A0_0000};
    mem_write_req_input = 1'b0;
    mem_read            = 32'hDEAD_BEEF;
    mem_read_valid      = 1'b1;
    mem_last            = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_enable", mem_enable, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_ch_read_valid", ch_read_valid, 0);
    chk("rst_ch_read", ch_read, 0);
    @(negedge clk);
    mem_read_valid = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk); #1;
    chk("t1_grant_id", grant_id, 0);
    chk("t1_busy", busy, 1);
    chk("t1_mem_addr", mem_addr, 16'h0010);
    ch_enable = 3'b000;
    mem_last  = 1'b1;
    @(negedge clk);
    mem_last = 1'b0;
    #1;
    chk("t1_release", busy, 0);

    // ---- 2. ch1 alone, 4-beat read
    ch_enable = 3'b010;
    @(negedge clk); #1;
    chk("t2_grant_id", grant_id, 1);
    chk("t2_mem_addr", mem_addr, 16'h0040);
    chk("t2_mem_rw", mem_rw, MEM_READ);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      mem_read_valid = 1'b1;
      mem_read       = 32'h1000 + b;
      mem_last       = (b == 3);
      if (b == 3) ch_enable = 3'b000;
      #1;
      chk("t2_ch_read_valid", ch_read_valid, 3'b010);
      chk("t2_ch_read", ch_read, 32'h1000 + b);
      chk("t2_ch_last", ch_last, (b == 3) ? 3'b010 : 3'b000);
      chk("t2_busy_in_burst", busy, 1);
    end
    @(negedge clk);
    mem_read_valid = 1'b0;
    mem_last       = 1'b0;
    #1;
    chk("t2_busy_after_last", busy, 0);
    chk("t2_mem_enable_idle", mem_enable, 0);

    // ---- 3. ch2 write burst, ch0 raises enable mid-burst
    ch_enable = 3'b100;
    @(negedge clk); #1;
    chk("t3_grant_id", grant_id, 2);
    chk("t3_mem_rw", mem_rw, MEM_WRITE);
    chk("t3_mem_write", mem_write, 32'hCAFE_0002);
    chk("t3_mem_op_size", mem_op_size, 1);
    chk("t3_mem_finishes_op", mem_finishes_op, 1);
    ch_enable           = 3'b101;
    mem_write_req_input = 1'b1;
    #1;
    chk("t3_ch_req_data", ch_req_data, 3'b100);
    @(negedge clk);
    mem_write_req_input = 1'b0;
    #1;
    chk("t3_sticky_grant", grant_id, 2);
    chk("t3_sticky_addr", mem_addr, 16'h0080);
    mem_last = 1'b1;
    #1;
    chk("t3_ch_last", ch_last, 3'b100);
    @(negedge clk);
    mem_last = 1'b0;
    #1;
    chk("t3_turnaround", busy, 0);
    @(negedge clk); #1;
    chk("t3_next_grant", grant_id, 0);
    chk("t3_next_addr", mem_addr, 16'h0010);
    chk("t3_next_write", mem_write, 32'hA0A0_0000);
    ch_enable = 3'b000;
    mem_last  = 1'b1;
    @(negedge clk);
    mem_last = 1'b0;
    #1;
    chk("t3_done", busy, 0);

    // ---- 4. all channels requesting for 3 bursts (fresh pointer)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    ch_enable = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t4_grant_seq", grant_id, exp_seq[k]);
      mem_last = 1'b1;
      @(negedge clk);
      mem_last = 1'b0;
      if (k == 2) ch_enable = 3'b000;
      #1;
      chk("t4_turnaround", busy, 0);
    end

    // ---- 5. mem_last while idle ignored; grantee drops enable mid-burst
    @(negedge clk);
    mem_last = 1'b1;
    @(negedge clk);
    mem_last  = 1'b0;
    ch_enable = 3'b010;
    #1;
    chk("t5_idle_last", busy, 0);
    @(negedge clk); #1;
    chk("t5_grant_id", grant_id, 1);
    ch_enable = 3'b000;
    @(negedge clk); #1;
    chk("t5_hold_1", mem_enable, 1);
    @(negedge clk); #1;
    chk("t5_hold_2", mem_enable, 1);
    chk("t5_hold_grant", grant_id, 1);
    mem_last = 1'b1;
    @(negedge clk);
    mem_last = 1'b0;
    #1;
    chk("t5_released", mem_enable, 0);
    @(negedge clk); #1;
    chk("t5_stays_idle", busy, 0);

    // ---- 6. async reset mid-burst
    ch_enable = 3'b100;
    @(negedge clk); #1;
    chk("t6_grant_id", grant_id, 2);
    mem_read_valid = 1'b1;
    #1;
    chk("t6_rv_before", ch_read_valid, 3'b100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_enable", mem_enable, 0);
    chk("t6_async_addr", mem_addr, 0);
    chk("t6_async_write", mem_write, 0);
    chk("t6_async_rv", ch_read_valid, 0);
    chk("t6_async_grant", grant_id, 0);
    @(negedge clk);
    mem_read_valid = 1'b0;
    ch_enable      = 3'b010;
    rst_n          = 1'b1;
    @(negedge clk); #1;
    chk("t6_rearb_grant", grant_id, 1);
    chk("t6_rearb_addr", mem_addr, 16'h0040);
    ch_enable = 3'b000;
    mem_last  = 1'b1;
    @(negedge clk);
    mem_last = 1'b0;
    #1;
    chk("t6_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
